dest_reg_pipe: RTL
==================

# dest_reg_pipe

- Carries the 3-bit destination register address produced by the ID-stage destination-select mux (rd vs rt) through the EX, MEM and WB stages of the DLX pipeline.
- From those in-flight destinations it generates three things:
  - the register-file write address and enable at WB;
  - a load-use hazard stall;
  - forwarding selects for the two ID-stage source operands.
- It sits directly downstream of the destination mux and feeds the register file and the operand-forwarding muxes.

## Interface
Parameters:
- AW, 3, register address width (8-entry register file).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- ID_DEST  input  AW  destination address from the destination-select mux.
- ID_WE  input  1  ID instruction writes a register.
- ID_LOAD  input  1  ID instruction is a load.
- ID_VALID  input  1  ID slot holds a real instruction.
- SRC_A, SRC_B  input  AW  ID-stage source register addresses.
- USE_A, USE_B  input  1  the corresponding source is actually read.
- STALL  input  1  external global hold.
- FLUSH  input  1  kill the instruction entering EX (branch taken).
- WB_DEST  output  AW  register-file write address.
- WB_WE  output  1  register-file write enable.
- HAZARD_STALL  output  1  load-use stall request to the fetch/decode stages.
- FWD_A, FWD_B  output  2  forwarding select: 00 register file, 01 EX, 10 MEM, 11 WB.

## Operation
Stage registers:
- EX, MEM and WB each hold {valid, we, load, dest}.
- An entry is live when valid & we & dest != 0. Register 0 is hardwired zero, so a dest of 0 never matches.

Advance, on each CLK edge, in priority order:
- RST: all valid, we and load bits are 0 and all dest fields are 0 (asynchronous).
- Else, if STALL: all stages hold.
- Else:
  - EX gets a bubble (valid=0) if FLUSH or HAZARD_STALL; otherwise it gets {ID_VALID, ID_WE, ID_LOAD, ID_DEST}.
  - MEM gets EX.
  - WB gets MEM.

Outputs:
- WB_DEST = WB.dest.
- WB_WE = WB.valid & WB.we & WB.dest != 0.

Hazard and forwarding logic (combinational, from ID sources vs stage registers):
- A source matches a stage when the source's USE bit is set, the stage is live, and the stage dest equals the source address.
- HAZARD_STALL = ID_VALID & (SRC_A or SRC_B matches EX) & EX.load.
- FWD_x selects the youngest matching stage: EX (01), then MEM (10), then WB (11), else 00. When no stage matches, FWD_x is 00.
- When EX is a matching load, FWD_x still reports 01. The stall masks that value, and after the bubble the load has moved to MEM, so the value recomputes to 10.
- FLUSH with HAZARD_STALL in the same cycle: EX gets a single bubble.
- STALL with HAZARD_STALL in the same cycle: STALL wins and nothing moves. HAZARD_STALL stays asserted.

## Timing
- ID to WB_WE latency: 3 cycles with no stalls.
- HAZARD_STALL, FWD_A and FWD_B are combinational in the same cycle as the ID inputs. Upstream holds ID while HAZARD_STALL=1.
- Load-use costs exactly one bubble: after one non-STALL edge the load is in MEM and HAZARD_STALL deasserts.
- Reset values:
  - WB_DEST=0, WB_WE=0, HAZARD_STALL=0, FWD_A=FWD_B=00.
  - These hold for the whole of reset and immediately after release.
- RST asserted mid-operation: all in-flight entries are discarded at once. No write occurs in the reset cycle.

## Configuration
- FWD_EN defined: forwarding as above.
- FWD_EN undefined (interlock-only core):
  - FWD_A and FWD_B are tied to 00.
  - HAZARD_STALL = ID_VALID & (SRC_A or SRC_B matches EX, MEM or WB), independent of the load bit.
  - A dependency therefore stalls until the producer leaves WB.

## Test plan
- Reset: assert RST during traffic. Required: WB_WE=0, WB_DEST=0, HAZARD_STALL=0 and FWD=00 immediately, and no writeback in any of the 3 cycles after release.
- Straight-line: ADD to R3, then SUB reading R3 (USE_A=1) on the next cycle. FWD_EN: FWD_A=01 and no stall, then WB_DEST=3 with WB_WE=1 three cycles after the ADD issues. Without FWD_EN: HAZARD_STALL=1 for 3 cycles.
- Load-use: load to R5 followed by a reader of R5 in SRC_B. Required: HAZARD_STALL=1 for exactly one cycle, a bubble in EX, then FWD_B=10.
- Register 0: a writer with dest 0 followed by a reader of R0. Required: FWD=00, no stall, and WB_WE=0 when it reaches WB.
- FLUSH: a writer to R2 enters EX with FLUSH=1. Required: it never reaches WB (WB_WE stays 0 for that slot), and a later reader of R2 gets FWD=00.
- STALL with a hazard pending: STALL=1 for 2 cycles while EX holds a load to R4 and ID reads R4. Required: all stages frozen and HAZARD_STALL stays 1; after STALL drops, one bubble, then normal flow.

Source files
------------

// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe
//   Carries the ID-stage destination register address through EX, MEM and WB
//   and derives the register-file write port, the load-use hazard stall and
//   the operand forwarding selects from the in-flight destinations.
//
//   Optional feature macro: FWD_EN
//     defined   : forwarding from EX/MEM/WB; only a load in EX stalls.
//     undefined : interlock-only; FWD_A/FWD_B tied to 00 and any dependency
//                 on EX, MEM or WB stalls until the producer has left WB.
//
// Ports
//   CLK, RST          rising-edge clock, asynchronous active-high reset
//   ID_DEST/WE/LOAD   destination, write flag, load flag of the ID instruction
//   ID_VALID          ID slot holds a real instruction
//   SRC_A/B, USE_A/B  ID source addresses and their read flags
//   STALL             global hold, freezes every stage
//   FLUSH             replace the instruction entering EX with a bubble
//   WB_DEST, WB_WE    register-file write address / enable
//   HAZARD_STALL      stall request to fetch/decode
//   FWD_A, FWD_B      00 regfile, 01 EX, 10 MEM, 11 WB
module dest_reg_pipe #(
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] ID_DEST,
  input  logic          ID_WE,
  input  logic          ID_LOAD,
  input  logic          ID_VALID,
  input  logic [AW-1:0] SRC_A,
  input  logic [AW-1:0] SRC_B,
  input  logic          USE_A,
  input  logic          USE_B,
  input  logic          STALL,
  input  logic          FLUSH,
  output logic [AW-1:0] WB_DEST,
  output logic          WB_WE,
  output logic          HAZARD_STALL,
  output logic [1:0]    FWD_A,
  output logic [1:0]    FWD_B
);

  // The load flag only matters while the producer sits in EX, so MEM and WB
  // do not carry it.
  logic          ex_valid, ex_we, ex_load;
  logic [AW-1:0] ex_dest;
  logic          mem_valid, mem_we;
  logic [AW-1:0] mem_dest;
  logic          wb_valid, wb_we;
  logic [AW-1:0] wb_dest;

  logic ex_live, mem_live, wb_live;
  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic hazard;

  // Register 0 is hardwired zero, so a zero destination never counts as live.
  assign ex_live  = ex_valid  & ex_we  & (ex_dest  != '0);
  assign mem_live = mem_valid & mem_we & (mem_dest != '0);
  assign wb_live  = wb_valid  & wb_we  & (wb_dest  != '0);

  assign a_ex  = USE_A & ex_live  & (ex_dest  == SRC_A);
  assign a_mem = USE_A & mem_live & (mem_dest == SRC_A);
  assign a_wb  = USE_A & wb_live  & (wb_dest  == SRC_A);
  assign b_ex  = USE_B & ex_live  & (ex_dest  == SRC_B);
  assign b_mem = USE_B & mem_live & (mem_dest == SRC_B);
  assign b_wb  = USE_B & wb_live  & (wb_dest  == SRC_B);

`ifdef FWD_EN
  assign hazard = ID_VALID & ex_load & (a_ex | b_ex);

  // Youngest producer wins; a matching load in EX still reports 01, the
  // stall masks it and after the bubble the load is seen in MEM.
  always_comb begin
    FWD_A = 2'b00;
    if (a_ex)       FWD_A = 2'b01;
    else if (a_mem) FWD_A = 2'b10;
    else if (a_wb)  FWD_A = 2'b11;
  end

  always_comb begin
    FWD_B = 2'b00;
    if (b_ex)       FWD_B = 2'b01;
    else if (b_mem) FWD_B = 2'b10;
    else if (b_wb)  FWD_B = 2'b11;
  end
`else
  // The ex_load term is subsumed by the EX match, so any dependency stalls
  // regardless of the load flag.
  assign hazard = ID_VALID & ((a_ex | a_mem | a_wb | b_ex | b_mem | b_wb)
                              | (ex_load & (a_ex | b_ex)));
  assign FWD_A  = 2'b00;
  assign FWD_B  = 2'b00;
`endif

  assign HAZARD_STALL = hazard;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_valid  <= 1'b0;
      ex_we     <= 1'b0;
      ex_load   <= 1'b0;
      ex_dest   <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_dest  <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_dest   <= '0;
    end else if (!STALL) begin
      if (FLUSH || hazard) begin
        ex_valid <= 1'b0;
        ex_we    <= 1'b0;
        ex_load  <= 1'b0;
        ex_dest  <= '0;
      end else begin
        ex_valid <= ID_VALID;
        ex_we    <= ID_WE;
        ex_load  <= ID_LOAD;
        ex_dest  <= ID_DEST;
      end
      mem_valid <= ex_valid;
      mem_we    <= ex_we;
      mem_dest  <= ex_dest;
      wb_valid  <= mem_valid;
      wb_we     <= mem_we;
      wb_dest   <= mem_dest;
    end
  end

  assign WB_DEST = wb_dest;
  assign WB_WE   = wb_live;

endmodule
